display_composer: RTL

//  Registered, parametrised successor to the combinational 7-seg display formatter.

---
 rtl/display_pkg.sv | 46 ++++
 rtl/display_composer_tick_divider.sv | 29 ++
 rtl/display_composer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared glyph codes, display_state encodings and the GAME-OVER banner ROM.
package display_pkg;

  localparam int unsigned G_A     = 10;
  localparam int unsigned G_D     = 13;
  localparam int unsigned G_E     = 14;
  localparam int unsigned G_G     = 16;
  localparam int unsigned G_H     = 17;
  localparam int unsigned G_I     = 18;
  localparam int unsigned G_L     = 19;
  localparam int unsigned G_M     = 20;
  localparam int unsigned G_P     = 21;
  localparam int unsigned G_S     = 22;
  localparam int unsigned G_T     = 23;
  localparam int unsigned G_V     = 24;
  localparam int unsigned G_DASH  = 25;
  localparam int unsigned G_BLANK = 26;
  localparam int unsigned G_R     = 27;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_TIME     = 4'd1;
  localparam logic [3:0] ST_SPEED    = 4'd2;
  localparam logic [3:0] ST_LEVEL    = 4'd3;
  localparam logic [3:0] ST_STANDBY  = 4'd4;
  localparam logic [3:0] ST_GAMEOVER = 4'd5;
  localparam logic [3:0] ST_BANNER   = 4'd6;

  localparam int unsigned MSG_LEN = 9;

  // Banner tape entry: "GAME-OVER" then blanks; the O reuses the zero glyph.
  function automatic int unsigned msg_glyph(input int unsigned idx);
    case (idx)
      32'd0:   return G_G;
      32'd1:   return G_A;
      32'd2:   return G_M;
      32'd3:   return G_E;
      32'd4:   return G_DASH;
      32'd5:   return 32'd0;
      32'd6:   return G_V;
      32'd7:   return G_E;
      32'd8:   return G_R;
      default: return G_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/display_composer_tick_divider.sv
// Free-running 0..DIV-1 counter; tick marks the terminal count, restart forces it to 0.
module tick_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  // restart wins over a coincident terminal count
  assign tick = !restart && (cnt == CW'(DIV - 1));

  // count, wrapping on terminal count or restart
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_composer.sv
// Registered 7-seg frame composer: layouts, blinking flash digit, scrolling banner.
module display_composer
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned GLYPH_W    = 5,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter int unsigned SCROLL_DIV = 12500000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    display_state,
  input  logic [1:0]                    level_number,
  input  logic [1:0]                    speed_number,
  input  logic [3:0]                    num_to_flash,
  input  logic                          no_num_to_flash,
  input  logic                          g_or_h,
  input  logic                          new_high,
  input  logic [3:0]                    score10s,
  input  logic [3:0]                    score1s,
  input  logic [3:0]                    timer10s,
  input  logic [3:0]                    timer1s,
  input  logic [3:0]                    best10s,
  input  logic [3:0]                    best1s,
  output logic [NUM_DIGITS*GLYPH_W-1:0] disp_flat,
  output logic                          blink_phase,
  output logic                          frame_strobe
);

  localparam int unsigned TAPE_L = MSG_LEN + NUM_DIGITS;
  localparam int unsigned IDX_W  = $clog2(TAPE_L);
  localparam int unsigned DISP_W = NUM_DIGITS * GLYPH_W;

  logic [3:0]         prev_state;
  logic [3:0]         prev_num;
  logic               prev_no_num;
  logic               blink_restart_c;
  logic               scroll_restart_c;
  logic               blink_tick;
  logic               scroll_tick;
  logic               phase_next;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;
  logic [GLYPH_W-1:0] frame [NUM_DIGITS];
  logic [DISP_W-1:0]  disp_next;
  int unsigned        tp;

  function automatic logic [GLYPH_W-1:0] bcd_glyph(input logic [3:0] v);
    return (v > 4'd9) ? GLYPH_W'(G_DASH) : GLYPH_W'(v);
  endfunction

  assign blink_restart_c = (display_state != prev_state)
                        || (!no_num_to_flash && (num_to_flash != prev_num))
                        || (prev_no_num && !no_num_to_flash);

  // scroll is parked at 0 outside BANNER and on the entry cycle
  assign scroll_restart_c = (display_state != ST_BANNER) || (prev_state != ST_BANNER);

  tick_divider #(.DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .restart (blink_restart_c),
    .tick    (blink_tick)
  );

  tick_divider #(.DIV(SCROLL_DIV)) u_scroll (
    .clk     (clk),
    .rst     (rst),
    .restart (scroll_restart_c),
    .tick    (scroll_tick)
  );

  // next blink phase and scroll index; the frame is built from these so it matches the registered phase
  always_comb begin
    phase_next = blink_phase;
    idx_next   = idx;
    if (blink_restart_c) begin
      phase_next = 1'b1;
    end else if (blink_tick) begin
      phase_next = !blink_phase;
    end
    if (scroll_restart_c) begin
      idx_next = '0;
    end else if (scroll_tick) begin
      idx_next = (idx == IDX_W'(TAPE_L - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // next-frame glyph mux
  always_comb begin
    tp = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      frame[i] = GLYPH_W'(G_BLANK);
    end
    case (display_state)
      ST_TIME: begin
        frame[0] = GLYPH_W'(G_T);
        frame[1] = GLYPH_W'(G_I);
        frame[2] = GLYPH_W'(G_M);
        frame[3] = GLYPH_W'(G_E);
        frame[4] = bcd_glyph(timer10s);
        frame[5] = bcd_glyph(timer1s);
      end
      ST_SPEED: begin
        frame[0] = GLYPH_W'(G_S);
        frame[1] = GLYPH_W'(G_P);
        frame[2] = GLYPH_W'(G_E);
        frame[3] = GLYPH_W'(G_E);
        frame[4] = GLYPH_W'(G_D);
        frame[5] = GLYPH_W'(speed_number);
      end
      ST_LEVEL: begin
        frame[0] = GLYPH_W'(G_L);
        frame[1] = GLYPH_W'(G_E);
        frame[2] = GLYPH_W'(G_V);
        frame[3] = GLYPH_W'(G_E);
        frame[4] = GLYPH_W'(G_L);
        frame[5] = GLYPH_W'(level_number);
      end
      ST_STANDBY: begin
        if (no_num_to_flash) begin
          frame[0] = GLYPH_W'(G_DASH);
        end else if (phase_next) begin
          frame[0] = bcd_glyph(num_to_flash);
        end else begin
          frame[0] = GLYPH_W'(G_BLANK);
        end
        frame[1] = GLYPH_W'(G_DASH);
        frame[2] = GLYPH_W'(G_DASH);
        frame[3] = GLYPH_W'(G_DASH);
        frame[4] = bcd_glyph(timer10s);
        frame[5] = bcd_glyph(timer1s);
      end
      ST_GAMEOVER: begin
        if (!(new_high && !phase_next)) begin
          frame[0] = GLYPH_W'(G_S);
          frame[1] = bcd_glyph(score10s);
          frame[2] = bcd_glyph(score1s);
          frame[3] = g_or_h ? GLYPH_W'(G_G) : GLYPH_W'(G_H);
          frame[4] = bcd_glyph(best10s);
          frame[5] = bcd_glyph(best1s);
        end
      end
      ST_BANNER: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          tp = 32'(idx_next) + i;
          if (tp >= TAPE_L) begin
            tp = tp - TAPE_L;
          end
          frame[i] = GLYPH_W'(msg_glyph(tp));
        end
      end
      default: begin
        for (int unsigned i = 0; i < 6; i++) begin
          frame[i] = GLYPH_W'(G_DASH);
        end
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pack
    assign disp_next[gi*GLYPH_W +: GLYPH_W] = frame[gi];
  end

  // frame register, change strobe and input history for restart detection
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_flat    <= {NUM_DIGITS{GLYPH_W'(G_DASH)}};
      blink_phase  <= 1'b1;
      frame_strobe <= 1'b0;
      idx          <= '0;
      prev_state   <= ST_IDLE;
      prev_num     <= 4'd0;
      prev_no_num  <= 1'b0;
    end else begin
      disp_flat    <= disp_next;
      blink_phase  <= phase_next;
      frame_strobe <= (disp_next != disp_flat);
      idx          <= idx_next;
      prev_state   <= display_state;
      prev_num     <= num_to_flash;
      prev_no_num  <= no_num_to_flash;
    end
  end

endmodule
